// File: rtl/pattern_detect_ctrl.sv
// Programmable serial pattern detector with run control: loads pattern and run limits over a
// valid/ready config port, counts overlapping matches and stops on target, timeout or abort.
module pattern_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_TARGET  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [3:0]       LEN_MAX = 4'(MAX_LEN);

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [3:0]         len_q;
    logic [CNT_W-1:0]   target_q;
    logic [TO_W-1:0]    timeout_q;
    logic [MAX_LEN-1:0] shift_q;
    logic [3:0]         fill_q;
    logic [TO_W-1:0]    timer_q;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] shift_nxt;
    logic [3:0]         fill_nxt;
    logic [3:0]         len_clamped;
    logic [CNT_W-1:0]   count_inc;
    logic [TO_W-1:0]    timer_inc;
    logic               is_match;
    logic               target_hit;
    logic               timeout_hit;

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (4'(i) < len_q);
        end
        shift_nxt   = {shift_q[MAX_LEN-2:0], bit_in};
        fill_nxt    = (fill_q < len_q) ? fill_q + 4'd1 : fill_q;
        is_match    = (fill_nxt >= len_q) && ((shift_nxt & len_mask) == (pat_q & len_mask));
        count_inc   = (match_count == '1) ? match_count : match_count + CNT_ONE;
        target_hit  = (target_q != '0) && (count_inc == target_q);
        timer_inc   = timer_q + TO_ONE;
        timeout_hit = (timeout_q != '0) && (timer_inc == timeout_q);
        len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            // NOTE: the stored config is reset too, so start stays dead until a fresh config arrives.
            pat_q       <= '0;
            len_q       <= '0;
            target_q    <= '0;
            timeout_q   <= '0;
            shift_q     <= '0;
            fill_q      <= '0;
            timer_q     <= '0;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= ST_NONE;
            match_pulse <= 1'b0;
            match_count <= '0;
        end else begin
            match_pulse <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (cfg_valid) begin
                        // A config load wins over a same-cycle start and drops any held result.
                        pat_q       <= cfg_pattern;
                        len_q       <= len_clamped;
                        target_q    <= cfg_target;
                        timeout_q   <= cfg_timeout;
                        state       <= S_IDLE;
                        done        <= 1'b0;
                        status      <= ST_NONE;
                        match_count <= '0;
                    end else if (start && (len_q != '0)) begin
                        state       <= S_SCAN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        cfg_ready   <= 1'b0;
                        status      <= ST_NONE;
                        shift_q     <= '0;
                        fill_q      <= '0;
                        timer_q     <= '0;
                        match_count <= '0;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cfg_ready <= 1'b1;
                        status    <= ST_ABORT;
                    end else begin
                        timer_q <= timer_inc;
                        if (bit_valid) begin
                            shift_q <= shift_nxt;
                            fill_q  <= fill_nxt;
                            if (is_match) begin
                                match_pulse <= 1'b1;
                                match_count <= count_inc;
                            end
                        end
                        if (bit_valid && is_match && target_hit) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                            status    <= ST_TARGET;
                        end else if (timeout_hit) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                            status    <= ST_TIMEOUT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
